// File: rtl/mdiv_pkg.sv
// Shared definitions for the mdiv sequential divider: FSM states, default width
// and the step-counter width helper.
package mdiv_pkg;

  localparam int MDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdiv_state_e;

  // Counter counts WIDTH-1 down to 0, so clog2(WIDTH) bits suffice.
  function automatic int mdiv_cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int MDIV_CNT_W = mdiv_cnt_w(MDIV_WIDTH);

endpackage

// File: rtl/mdiv_step.sv
// One combinational radix-2 restoring division step: shifts the next dividend bit
// into the partial remainder and subtracts the divisor when it fits.
module mdiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] r_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] t;

  // R < A holds on entry, so {R,q} < 2A and the top bit of t is a true sign bit.
  assign t       = {r_i, q_msb_i} - {1'b0, a_i};
  assign q_bit_o = ~t[WIDTH];
  assign r_o     = t[WIDTH] ? {r_i[WIDTH-2:0], q_msb_i} : t[WIDTH-1:0];

endmodule

// File: rtl/mdiv.sv
// Sequential restoring divider, one quotient bit per clock: Z = A*B + C, C < A.
// Define MDIV_SIGNED_EN for two's-complement operands (truncation toward zero).
module mdiv
  import mdiv_pkg::*;
#(
  parameter int WIDTH = MDIV_WIDTH
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             START,
  input  logic [WIDTH-1:0] Z,
  input  logic [WIDTH-1:0] A,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic             DZ
);

  localparam int CNT_W = mdiv_cnt_w(WIDTH);

  mdiv_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] r_nxt, q_nxt;
  logic             q_bit;
  logic [WIDTH-1:0] z_mag, a_mag, b_res, c_res;

  mdiv_step #(.WIDTH(WIDTH)) u_step (
    .r_i    (r_q),
    .q_msb_i(q_q[WIDTH-1]),
    .a_i    (a_q),
    .r_o    (r_nxt),
    .q_bit_o(q_bit)
  );

  assign q_nxt = {q_q[WIDTH-2:0], q_bit};

`ifdef MDIV_SIGNED_EN
  logic neg_b_q, neg_b_d;
  logic neg_c_q, neg_c_d;

  assign z_mag = Z[WIDTH-1] ? -Z : Z;
  assign a_mag = A[WIDTH-1] ? -A : A;
  assign b_res = neg_b_q ? -q_nxt : q_nxt;
  assign c_res = neg_c_q ? -r_nxt : r_nxt;
  assign neg_b_d = (state_q != ST_CALC && START) ? (Z[WIDTH-1] ^ A[WIDTH-1]) : neg_b_q;
  assign neg_c_d = (state_q != ST_CALC && START) ? Z[WIDTH-1] : neg_c_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      neg_b_q <= 1'b0;
      neg_c_q <= 1'b0;
    end else begin
      neg_b_q <= neg_b_d;
      neg_c_q <= neg_c_d;
    end
  end
`else
  assign z_mag = Z;
  assign a_mag = A;
  assign b_res = q_nxt;
  assign c_res = r_nxt;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    dz_d    = dz_q;
    case (state_q)
      ST_CALC: begin
        r_d   = r_nxt;
        q_d   = q_nxt;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          b_d     = b_res;
          c_d     = c_res;
          dz_d    = 1'b0;
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (START) begin
          if (A == '0) begin
            // Divide-by-zero skips the iteration and reports the raw dividend.
            b_d     = '1;
            c_d     = Z;
            dz_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            a_d     = a_mag;
            q_d     = z_mag;
            r_d     = '0;
            cnt_d   = CNT_W'(WIDTH - 1);
            state_d = ST_CALC;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      dz_q    <= dz_d;
    end
  end

  assign BUSY = (state_q == ST_CALC);
  assign DONE = (state_q == ST_DONE);
  assign B    = b_q;
  assign C    = c_q;
  assign DZ   = dz_q;

endmodule

// File: tb/tb_mdiv.sv
// Directed self-checking bench for mdiv (WIDTH=32) with hand-computed results.
module tb_mdiv;

  logic        CLK;
  logic        RSTN;
  logic        START;
  logic [31:0] Z;
  logic [31:0] A;
  logic        BUSY;
  logic        DONE;
  logic [31:0] B;
  logic [31:0] C;
  logic        DZ;

  int n_vec = 0;
  int n_err = 0;

  mdiv #(.WIDTH(32)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .START(START),
    .Z    (Z),
    .A    (A),
    .BUSY (BUSY),
    .DONE (DONE),
    .B    (B),
    .C    (C),
    .DZ   (DZ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Samples start just after the accepting edge; lat counts edges until DONE is seen.
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    while (!DONE) begin
      if (BUSY) busy_n++;
      tick();
      lat++;
      if (lat > 200) begin
        chk("done_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  task automatic do_op(input logic [31:0] z, input logic [31:0] a, output int lat, output int busy_n);
    Z     = z;
    A     = a;
    START = 1'b1;
    tick();
    START = 1'b0;
    wait_done(lat, busy_n);
    $display("op Z=%h A=%h -> B=%h C=%h DZ=%b lat=%0d busy=%0d", z, a, B, C, DZ, lat, busy_n);
  endtask

  task automatic div_case(input string tag, input logic [31:0] z, input logic [31:0] a,
                          input logic [31:0] exp_b, input logic [31:0] exp_c);
    int lat, busy_n;
    do_op(z, a, lat, busy_n);
    chk({tag, "_lat"}, 32'(lat), 32'd32);
    chk({tag, "_busy"}, 32'(busy_n), 32'd32);
    chk({tag, "_b"}, B, exp_b);
    chk({tag, "_c"}, C, exp_c);
    chk({tag, "_dz"}, {31'd0, DZ}, 32'd0);
    chk({tag, "_recon"}, a * B + C, z);
    tick();
  endtask

  initial begin
    int lat, busy_n, dones;

    // Reset held with a pending request: nothing may be captured.
    RSTN  = 1'b0;
    START = 1'b1;
    Z     = 32'd100;
    A     = 32'd7;
    repeat (3) tick();
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_b", B, 32'd0);
    chk("rst_c", C, 32'd0);
    chk("rst_dz", {31'd0, DZ}, 32'd0);
    START = 1'b0;
    RSTN  = 1'b1;
    tick();
    chk("rst_idle_busy", {31'd0, BUSY}, 32'd0);
    $display("reset checked");

    // Basic operation and hold in IDLE.
    div_case("d100_7", 32'd100, 32'd7, 32'd14, 32'd2);
    chk("hold_done", {31'd0, DONE}, 32'd0);
    chk("hold_b", B, 32'd14);
    chk("hold_c", C, 32'd2);

    div_case("d1e6_3", 32'd1000000, 32'd3, 32'd333333, 32'd1);
    div_case("d5_7", 32'd5, 32'd7, 32'd0, 32'd5);
    div_case("dmax_1", 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0);
    div_case("dmax_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd1, 32'd0);
    div_case("dones_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0);
    div_case("dones_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);

    // Divide by zero: result in the cycle right after acceptance, no BUSY.
    do_op(32'h1234, 32'd0, lat, busy_n);
    chk("dz_lat", 32'(lat), 32'd0);
    chk("dz_busy", {31'd0, BUSY}, 32'd0);
    chk("dz_b", B, 32'hFFFF_FFFF);
    chk("dz_c", C, 32'h1234);
    chk("dz_flag", {31'd0, DZ}, 32'd1);
    tick();
    chk("dz_done_pulse", {31'd0, DONE}, 32'd0);
    chk("dz_busy_after", {31'd0, BUSY}, 32'd0);

    // START held; operands change mid-CALC and must not disturb the result.
    Z     = 32'd100;
    A     = 32'd7;
    START = 1'b1;
    tick();
    Z = 32'd9;
    A = 32'd3;
    wait_done(lat, busy_n);
    $display("op Z=%h A=%h -> B=%h C=%h DZ=%b lat=%0d busy=%0d", 32'd100, 32'd7, B, C, DZ, lat, busy_n);
    chk("b2b_first_lat", 32'(lat), 32'd32);
    chk("b2b_first_b", B, 32'd14);
    chk("b2b_first_c", C, 32'd2);
    chk("b2b_first_dz", {31'd0, DZ}, 32'd0);
    tick();
    START = 1'b0;
    chk("b2b_accept_busy", {31'd0, BUSY}, 32'd1);
    chk("b2b_accept_done", {31'd0, DONE}, 32'd0);
    wait_done(lat, busy_n);
    $display("op Z=%h A=%h -> B=%h C=%h DZ=%b lat=%0d busy=%0d", 32'd9, 32'd3, B, C, DZ, lat, busy_n);
    chk("b2b_second_lat", 32'(lat), 32'd32);
    chk("b2b_second_b", B, 32'd3);
    chk("b2b_second_c", C, 32'd0);
    tick();

    // Asynchronous reset ten cycles into CALC discards the operation.
    Z     = 32'd100;
    A     = 32'd7;
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (10) tick();
    chk("mid_busy_pre", {31'd0, BUSY}, 32'd1);
    RSTN = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, BUSY}, 32'd0);
    chk("mid_rst_done", {31'd0, DONE}, 32'd0);
    chk("mid_rst_b", B, 32'd0);
    chk("mid_rst_c", C, 32'd0);
    chk("mid_rst_dz", {31'd0, DZ}, 32'd0);
    tick();
    tick();
    RSTN  = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (DONE || BUSY) dones++;
    end
    chk("mid_no_done", 32'(dones), 32'd0);
    $display("mid-calc reset checked");
    div_case("d50_5", 32'd50, 32'd5, 32'd10, 32'd0);

    // Sign handling depends on the build.
    do_op(32'hFFFF_FFF9, 32'd2, lat, busy_n);
    chk("sgn_lat", 32'(lat), 32'd32);
`ifdef MDIV_SIGNED_EN
    chk("sgn_b", B, 32'hFFFF_FFFD);
    chk("sgn_c", C, 32'hFFFF_FFFF);
`else
    chk("sgn_b", B, 32'h7FFF_FFFC);
    chk("sgn_c", C, 32'd1);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
